stabilizer_array_scheduler: RTL and testbench
=============================================

STABILIZER_ARRAY_SCHEDULER -- requirements
Module: stabilizer_array_scheduler

Interface
REQ-001 SHALL have parameter NUM_QUBIT, default 4, number of rows/columns of the stabilizer register array (>=2).
REQ-002 SHALL have localparam CW = max(1, clog2(NUM_QUBIT)), the column-index width.
REQ-003 SHALL have port clk  input  1  clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_cof  input  1  cofactor client requests a NUM_QUBIT-row load; held until done.
REQ-006 SHALL have port cof_valid  input  1  cofactor row available this cycle.
REQ-007 SHALL have port req_can  input  1  canonical client requests a NUM_QUBIT-row load; held until done.
REQ-008 SHALL have port can_valid  input  1  canonical row available this cycle.
REQ-009 SHALL have port req_out  input  1  consumer requests rotate-out of all rows; held until done.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the bottom row this cycle.
REQ-011 SHALL have port req_beta  input  1  beta-operation request; held until done.
REQ-012 SHALL have port beta_col  input  CW  target column for beta, valid while req_beta=1, range 0..NUM_QUBIT-1.
REQ-013 SHALL have ports shift_in_cof, shift_in_can, rotate_down, rotate_left  output  1 each  array control strobes.
REQ-014 SHALL have port grant  output  4  one-hot owner {beta,out,can,cof}, 0 when idle.
REQ-015 SHALL have ports done  output  1  one-cycle completion pulse; busy  output  1  grant!=0; array_full  output  1  array holds valid rows.

Function
REQ-016 SHALL implement states IDLE, LOAD, ROTOUT, BETA_LEFT, BETA_DOWN, BETA_RESTORE, DONE.
REQ-017 In IDLE, eligible requests: req_out, req_beta only when array_full=1; req_cof, req_can only when array_full=0.
REQ-018 Fixed priority among eligible: out > beta > cof > can; ineligible requests wait, never granted.
REQ-019 Grant SHALL register on the clock edge after the request is sampled in IDLE; one cycle request-to-grant latency.
REQ-020 Row counter width CW+1, cleared on every grant.
REQ-021 LOAD: shift_in_cof = grant[0]&cof_valid, shift_in_can = grant[1]&can_valid (combinational from registered state); counter increments per strobe; after NUM_QUBIT strobes go DONE, set array_full.
REQ-022 ROTOUT: rotate_down = out_ready; counter increments per strobe; after NUM_QUBIT strobes go DONE, clear array_full.
REQ-023 BETA_LEFT: rotate_left=1 each cycle for beta_col cycles (beta_col latched at grant); beta_col=0 skips directly to BETA_DOWN.
REQ-024 BETA_DOWN: rotate_down=1 each cycle for NUM_QUBIT cycles (full rotation, array contents preserved).
REQ-025 BETA_RESTORE: rotate_left=1 for (NUM_QUBIT-beta_col) mod NUM_QUBIT cycles, restoring column order; zero count skips to DONE.
REQ-026 At most one strobe asserted per cycle; all strobes 0 outside LOAD/ROTOUT/BETA_*.
REQ-027 DONE: done=1 for exactly one cycle, grant cleared, return to IDLE; new grant earliest the following cycle.
REQ-028 Request deasserted mid-operation SHALL be ignored; operation completes.
REQ-029 beta_col>=NUM_QUBIT SHALL be treated as beta_col mod NUM_QUBIT.

Reset
REQ-030 On rst: state IDLE, counter 0, grant 0, array_full 0, done 0, busy 0, all strobes 0, immediately and asynchronously.
REQ-031 rst mid-operation SHALL abort without further strobes; array_full 0 after release.

Verification
REQ-032 NUM_QUBIT=4, req_cof=1, cof_valid pattern 1,0,1,1,1 -> grant=0001 next cycle, exactly 4 shift_in_cof pulses, done one cycle later, array_full=1.
REQ-033 array_full=1, req_out and req_cof simultaneous -> grant=0100, req_cof waits; out_ready=1 steady -> 4 rotate_down, done, array_full=0, then grant=0001.
REQ-034 array_full=1, req_beta, beta_col=1 -> rotate_left x1, rotate_down x4, rotate_left x3, done; total 8 strobe cycles.
REQ-035 array_full=1, req_beta, beta_col=0 -> rotate_down x4 only, no rotate_left, done.
REQ-036 rst asserted during LOAD after 2 strobes -> all outputs 0 immediately; post-reset req_out ignored (array_full=0).

Source files
------------

// File: rtl/stabilizer_array_scheduler.sv
// Stabilizer array scheduler: arbitrates four clients (cofactor load,
// canonical load, rotate-out, beta operation) for a NUM_QUBIT x NUM_QUBIT
// stabilizer register array and sequences the array control strobes.
//
// Ports
//   clk, rst           clock; asynchronous active-high reset
//   req_cof/cof_valid  cofactor load request / row available
//   req_can/can_valid  canonical load request / row available
//   req_out/out_ready  rotate-out request / consumer accepts bottom row
//   req_beta/beta_col  beta request / target column
//   shift_in_cof, shift_in_can, rotate_down, rotate_left   array strobes
//   grant              one-hot owner {beta,out,can,cof}, 0 when idle
//   done               one-cycle completion pulse
//   busy               grant != 0
//   array_full         array holds valid rows
module stabilizer_array_scheduler #(
  parameter int NUM_QUBIT = 4,
  localparam int CW = ($clog2(NUM_QUBIT) < 1) ? 1 : $clog2(NUM_QUBIT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_cof,
  input  logic          cof_valid,
  input  logic          req_can,
  input  logic          can_valid,
  input  logic          req_out,
  input  logic          out_ready,
  input  logic          req_beta,
  input  logic [CW-1:0] beta_col,
  output logic          shift_in_cof,
  output logic          shift_in_can,
  output logic          rotate_down,
  output logic          rotate_left,
  output logic [3:0]    grant,
  output logic          done,
  output logic          busy,
  output logic          array_full
);

  localparam logic [CW:0] NQ = (CW+1)'(NUM_QUBIT);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROTOUT,
    BETA_LEFT,
    BETA_DOWN,
    BETA_RESTORE,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW:0]   cnt_q, cnt_d;
  logic [3:0]    grant_q, grant_d;
  logic          full_q, full_d;
  logic [CW-1:0] col_q, col_d;

  logic [CW:0]   cnt_inc;
  logic [CW:0]   col_mod;
  logic [CW:0]   restore_len;

  assign cnt_inc = cnt_q + 1'b1;
  // Only reduces anything when NUM_QUBIT is not a power of two.
  assign col_mod = {1'b0, beta_col} % NQ;
  // (NUM_QUBIT - col) mod NUM_QUBIT: column 0 needs no restoring shifts.
  assign restore_len = (col_q == '0) ? '0 : (NQ - {1'b0, col_q});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      full_q  <= 1'b0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      full_q  <= full_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    full_d       = full_q;
    col_d        = col_q;
    shift_in_cof = 1'b0;
    shift_in_can = 1'b0;
    rotate_down  = 1'b0;
    rotate_left  = 1'b0;
    done         = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Unload/beta need a full array, loads need an empty one.
        if (full_q && req_out) begin
          grant_d = 4'b0100;
          cnt_d   = '0;
          state_d = ROTOUT;
        end else if (full_q && req_beta) begin
          grant_d = 4'b1000;
          cnt_d   = '0;
          col_d   = col_mod[CW-1:0];
          state_d = (col_mod == '0) ? BETA_DOWN : BETA_LEFT;
        end else if (!full_q && req_cof) begin
          grant_d = 4'b0001;
          cnt_d   = '0;
          state_d = LOAD;
        end else if (!full_q && req_can) begin
          grant_d = 4'b0010;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end

      LOAD: begin
        shift_in_cof = grant_q[0] & cof_valid;
        shift_in_can = grant_q[1] & can_valid;
        if (shift_in_cof || shift_in_can) begin
          cnt_d = cnt_inc;
          if (cnt_inc == NQ) begin
            state_d = DONE;
            grant_d = '0;
            full_d  = 1'b1;
          end
        end
      end

      ROTOUT: begin
        rotate_down = out_ready;
        if (out_ready) begin
          cnt_d = cnt_inc;
          if (cnt_inc == NQ) begin
            state_d = DONE;
            grant_d = '0;
            full_d  = 1'b0;
          end
        end
      end

      BETA_LEFT: begin
        rotate_left = 1'b1;
        cnt_d       = cnt_inc;
        if (cnt_inc == {1'b0, col_q}) begin
          cnt_d   = '0;
          state_d = BETA_DOWN;
        end
      end

      BETA_DOWN: begin
        rotate_down = 1'b1;
        cnt_d       = cnt_inc;
        if (cnt_inc == NQ) begin
          cnt_d = '0;
          if (restore_len == '0) begin
            state_d = DONE;
            grant_d = '0;
          end else begin
            state_d = BETA_RESTORE;
          end
        end
      end

      BETA_RESTORE: begin
        rotate_left = 1'b1;
        cnt_d       = cnt_inc;
        if (cnt_inc == restore_len) begin
          cnt_d   = '0;
          state_d = DONE;
          grant_d = '0;
        end
      end

      DONE: begin
        done    = 1'b1;
        grant_d = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign grant      = grant_q;
  assign busy       = |grant_q;
  assign array_full = full_q;

endmodule

// File: tb/tb_stabilizer_array_scheduler.sv
// Directed self-checking bench for stabilizer_array_scheduler (NUM_QUBIT=4).
// Strobe cycles are logged as octal digits into `trace`
// (1=shift_in_cof, 2=shift_in_can, 3=rotate_down, 4=rotate_left).
module tb_stabilizer_array_scheduler;

  localparam int NQ = 4;
  localparam int CW = 2;

  logic          clk;
  logic          rst;
  logic          req_cof, cof_valid, req_can, can_valid;
  logic          req_out, out_ready, req_beta;
  logic [CW-1:0] beta_col;
  logic          shift_in_cof, shift_in_can, rotate_down, rotate_left;
  logic [3:0]    grant;
  logic          done, busy, array_full;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned trace;
  int unsigned nsteps;
  int unsigned multi;
  logic [4:0]  pat;

  stabilizer_array_scheduler #(.NUM_QUBIT(NQ)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_cof     (req_cof),
    .cof_valid   (cof_valid),
    .req_can     (req_can),
    .can_valid   (can_valid),
    .req_out     (req_out),
    .out_ready   (out_ready),
    .req_beta    (req_beta),
    .beta_col    (beta_col),
    .shift_in_cof(shift_in_cof),
    .shift_in_can(shift_in_can),
    .rotate_down (rotate_down),
    .rotate_left (rotate_left),
    .grant       (grant),
    .done        (done),
    .busy        (busy),
    .array_full  (array_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  function automatic int unsigned nstrobe();
    return int'(shift_in_cof) + int'(shift_in_can) + int'(rotate_down) + int'(rotate_left);
  endfunction

  // Sample strobes mid-cycle, then advance to just after the next edge.
  task automatic step();
    int unsigned n;
    #1;
    n = nstrobe();
    if (n > 1) multi++;
    if (n == 1) begin
      if (shift_in_cof)      trace = trace * 8 + 1;
      else if (shift_in_can) trace = trace * 8 + 2;
      else if (rotate_down)  trace = trace * 8 + 3;
      else                   trace = trace * 8 + 4;
    end
    nsteps++;
    @(posedge clk);
    #2;
  endtask

  task automatic run_until_done(input string tag, input int unsigned bound);
    for (int unsigned k = 0; k < bound && !done; k++) step();
    check(tag, 32'(done), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_cof = 0; cof_valid = 0; req_can = 0; can_valid = 0;
    req_out = 0; out_ready = 0; req_beta = 0; beta_col = '0;
    trace = 0; nsteps = 0; multi = 0;
    #3;
    check("rst_grant", 32'(grant), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_full", 32'(array_full), 0);
    check("rst_strobes", nstrobe(), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #2;

    // Cofactor load with a gap in cof_valid.
    req_cof = 1;
    check("idle_no_grant", 32'(grant), 0);
    step();
    check("grant_cof", 32'(grant), 1);
    check("busy_cof", 32'(busy), 1);
    trace = 0;
    pat = 5'b11101;
    for (int i = 0; i < 5; i++) begin
      cof_valid = pat[i];
      step();
    end
    cof_valid = 0;
    check("load_done", 32'(done), 1);
    check("load_trace", trace, 'o1111);
    check("load_full", 32'(array_full), 1);
    check("load_grant_clr", 32'(grant), 0);
    req_cof = 0;
    step();
    check("done_pulse", 32'(done), 0);

    // Canonical load is ineligible while the array is full.
    req_can = 1;
    step();
    step();
    check("can_inelig", 32'(grant), 0);
    req_can = 0;

    // Rotate-out wins over a simultaneous cofactor request.
    req_out = 1; req_cof = 1; out_ready = 1;
    step();
    check("grant_out", 32'(grant), 4);
    req_out = 0;
    trace = 0;
    run_until_done("rotout_fin", 10);
    check("rotout_trace", trace, 'o3333);
    check("rotout_empty", 32'(array_full), 0);
    out_ready = 0;
    step();
    check("cof_waits", 32'(grant), 0);
    step();
    check("grant_cof2", 32'(grant), 1);
    cof_valid = 1;
    trace = 0;
    run_until_done("load2_fin", 10);
    req_cof = 0; cof_valid = 0;
    check("load2_trace", trace, 'o1111);
    check("load2_full", 32'(array_full), 1);
    step();

    // Beta col=1; request and column change mid-op must be ignored.
    req_beta = 1; beta_col = 2'd1;
    step();
    check("grant_beta", 32'(grant), 8);
    req_beta = 0; beta_col = 2'd3;
    trace = 0; nsteps = 0;
    run_until_done("beta1_fin", 20);
    check("beta1_trace", trace, 'o43333444);
    check("beta1_cycles", nsteps, 8);
    check("beta1_full", 32'(array_full), 1);
    step();

    // Beta col=3.
    req_beta = 1; beta_col = 2'd3;
    step();
    req_beta = 0; beta_col = 2'd0;
    trace = 0;
    run_until_done("beta3_fin", 20);
    check("beta3_trace", trace, 'o44433334);
    step();

    // Beta col=0: rotation only.
    req_beta = 1; beta_col = 2'd0;
    step();
    req_beta = 0;
    trace = 0; nsteps = 0;
    run_until_done("beta0_fin", 20);
    check("beta0_trace", trace, 'o3333);
    check("beta0_cycles", nsteps, 4);
    step();

    // Out beats beta; out_ready gap stalls the rotation.
    req_out = 1; req_beta = 1; beta_col = 2'd2;
    step();
    check("out_over_beta", 32'(grant), 4);
    req_out = 0; req_beta = 0;
    trace = 0; nsteps = 0;
    for (int unsigned k = 0; k < 10 && !done; k++) begin
      out_ready = (k != 1);
      step();
    end
    out_ready = 0;
    check("rotout2_fin", 32'(done), 1);
    check("rotout2_trace", trace, 'o3333);
    check("rotout2_cycles", nsteps, 5);
    check("rotout2_empty", 32'(array_full), 0);
    step();

    // Reset in the middle of a load.
    req_cof = 1;
    step();
    check("grant_cof3", 32'(grant), 1);
    cof_valid = 1;
    step();
    step();
    #1;
    check("pre_rst_shift", 32'(shift_in_cof), 1);
    rst = 1;
    #1;
    check("arst_grant", 32'(grant), 0);
    check("arst_strobes", nstrobe(), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    check("arst_full", 32'(array_full), 0);
    req_cof = 0; cof_valid = 0;
    @(negedge clk) rst = 0;
    req_out = 1; out_ready = 1;
    @(posedge clk);
    #2;
    step();
    step();
    #1;
    check("post_rst_out_ign", 32'(grant), 0);
    check("post_rst_no_rot", 32'(rotate_down), 0);
    check("multi_strobe", multi, 0);
    req_out = 0; out_ready = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
